// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output and error flags
// Centre-sampling receiver: 2-flop sync, start glitch rejection, parity/framing/overrun flags.
module uart_rx_param #(
  parameter int FREQ      = 12000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB = FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 ferr;
  logic                 accept;
  logic                 bit_end;

  assign accept  = rx_valid && rx_ready;
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (accept) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state    <= S_DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              perr     <= 1'b0;
              ferr     <= 1'b0;
            end else begin
              // start bit vanished before its centre: line glitch
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST)
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            perr  <= ((^shift) ^ rx_s) != PAR_ODD;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              // commit; a pending unaccepted word is overwritten
              rx_data    <= shift;
              parity_err <= perr;
              frame_err  <= ferr | ~rx_s;
              rx_valid   <= 1'b1;
              overrun    <= rx_valid && !rx_ready;
              state      <= S_IDLE;
              busy       <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
              ferr     <= ferr | ~rx_s;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1 and 8E1 instances, CPB=16)
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] d0, d1;
  logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, b0, b1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise0, rise1, ovc0, ovc1, busyc0;
  int st_cyc;
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;

  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         pbit;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[9];

  uart_rx_param #(.FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .nrst(nrst), .rx_in(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0)
  );

  uart_rx_param #(.FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .nrst(nrst), .rx_in(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 && !pv0) rise0 = cyc;
    if (v1 && !pv1) rise1 = cyc;
    pv0 = v0;
    pv1 = v1;
    if (ov0) ovc0++;
    if (ov1) ovc1++;
    if (b0) busyc0++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: expected word and flags from the frame contents alone.
  function automatic void model(input bit par, input logic [7:0] data, input bit pbit,
                                input bit stop, output logic [7:0] ed, output bit epe,
                                output bit efe);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    ones += int'(pbit);
    ed  = data;
    epe = par ? ((ones % 2) != 0) : 1'b0;
    efe = !stop;
  endfunction

  function automatic int exp_latency(input bit par);
    return 3 + (8 + int'(par) + 1) * CPB + CPB / 2;
  endfunction

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx1 = v;
    else rx0 = v;
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] data, input bit pbit, input bit stop);
    st_cyc = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (sel) drive_bit(sel, pbit);
    drive_bit(sel, stop);
    set_line(sel, 1'b1);
  endtask

  task automatic accept(input bit sel, input string nm);
    if (sel) rdy1 = 1'b1;
    else rdy0 = 1'b1;
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    chk({nm, ".valid_drop"}, sel ? int'(v1) : int'(v0), 0);
  endtask

  task automatic check_frame(input bit sel, input logic [7:0] data, input bit pbit,
                             input bit stop, input logic [7:0] ed, input bit epe,
                             input bit efe, input string nm);
    int st;
    rise0 = -1;
    rise1 = -1;
    send(sel, data, pbit, stop);
    st = st_cyc;
    repeat (20) @(posedge clk);
    #1;
    chk({nm, ".valid"},   sel ? int'(v1)  : int'(v0),  1);
    chk({nm, ".data"},    sel ? int'(d1)  : int'(d0),  int'(ed));
    chk({nm, ".perr"},    sel ? int'(pe1) : int'(pe0), int'(epe));
    chk({nm, ".ferr"},    sel ? int'(fe1) : int'(fe0), int'(efe));
    chk({nm, ".latency"}, (sel ? rise1 : rise0) - st, exp_latency(sel));
    accept(sel, nm);
  endtask

  initial begin
    logic [7:0] ed, rd;
    bit epe, efe, rsel, rpb, rst;

    vecs[0] = '{0, 8'hA5, 0, 1, 8'hA5, 0, 0};
    vecs[1] = '{0, 8'h3C, 0, 0, 8'h3C, 0, 1};
    vecs[2] = '{0, 8'h3C, 0, 1, 8'h3C, 0, 0};
    vecs[3] = '{0, 8'h00, 0, 1, 8'h00, 0, 0};
    vecs[4] = '{0, 8'hFF, 0, 1, 8'hFF, 0, 0};
    vecs[5] = '{1, 8'h07, 1, 1, 8'h07, 0, 0};
    vecs[6] = '{1, 8'h07, 0, 1, 8'h07, 1, 0};
    vecs[7] = '{1, 8'hFF, 0, 1, 8'hFF, 0, 0};
    vecs[8] = '{1, 8'h80, 0, 0, 8'h80, 1, 1};

    // reset with line low
    nrst = 1'b0; rx0 = 1'b0; rx1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.data",  int'(d0),  0);
    chk("rst.valid", int'(v0),  0);
    chk("rst.perr",  int'(pe0), 0);
    chk("rst.ferr",  int'(fe0), 0);
    chk("rst.ovr",   int'(ov0), 0);
    chk("rst.busy",  int'(b0),  0);
    chk("rst.busy1", int'(b1),  0);
    rx0 = 1'b1; rx1 = 1'b1; nrst = 1'b1;
    busyc0 = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("idle.busy_cycles", busyc0, 0);
    chk("idle.valid", int'(v0), 0);

    // table vectors
    for (int i = 0; i < 9; i++)
      check_frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].stop,
                  vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr,
                  $sformatf("vec%0d", i));

    // start glitch of 5 clocks
    busyc0 = 0;
    rx0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch.busy_cycles", busyc0, CPB / 2);
    chk("glitch.valid", int'(v0), 0);
    chk("glitch.busy", int'(b0), 0);

    // back-to-back without accept: overrun once
    ovc0 = 0;
    send(0, 8'h11, 0, 1);
    send(0, 8'h22, 0, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("ovr.count", ovc0, 1);
    chk("ovr.data", int'(d0), 8'h22);
    chk("ovr.valid", int'(v0), 1);
    accept(0, "ovr");

    // accept in the commit cycle: new word wins, no overrun
    ovc0 = 0;
    send(0, 8'h11, 0, 1);
    fork
      send(0, 8'h22, 0, 1);
      begin
        repeat (exp_latency(0) - 1) @(posedge clk);
        #1;
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        rdy0 = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("same.count", ovc0, 0);
    chk("same.valid", int'(v0), 1);
    chk("same.data", int'(d0), 8'h22);
    accept(0, "same");

    // reset in the middle of bit 4
    rd = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, rd[i]);
    rx0 = rd[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    nrst = 1'b0;
    rx0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.busy", int'(b0), 0);
    nrst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("midrst.valid", int'(v0), 0);
    chk("midrst.busy_after", int'(b0), 0);
    model(0, 8'h5A, 0, 1, ed, epe, efe);
    check_frame(0, 8'h5A, 0, 1, ed, epe, efe, "after_rst");

    // randomized frames against the reference model
    for (int i = 0; i < 16; i++) begin
      rsel = 1'($urandom % 2);
      rd   = 8'($urandom);
      rpb  = 1'($urandom % 2);
      rst  = (($urandom % 4) != 0);
      model(rsel, rd, rpb, rst, ed, epe, efe);
      check_frame(rsel, rd, rpb, rst, ed, epe, efe, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
